fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage of the reduced RISC-V core, directly upstream of the immediate sign-extension stage and the decoder.
- Holds the program counter and requests instruction words from instruction memory over a valid handshake.
- Presents one instruction at a time, with its PC, to the decode stage.
- Computes the next PC from the issued instruction's PC: either PC+4 or the branch target PC+ImmOp, using the ImmOp fed back from sign extension.

Parameters:
- DATA_WIDTH, 32, instruction and immediate width.
- ADDR_WIDTH, 32, PC and instruction-memory address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction register value while no instruction is valid.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- pcsrc  in  1  1 = issued instruction takes its branch/jump; 0 = sequential.
- immop  in  DATA_WIDTH  sign-extended immediate of the issued instruction.
- stall  in  1  decode/execute cannot accept the issued instruction this cycle.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_WIDTH  word address of the request; always equals pc.
- imem_rdata  in  DATA_WIDTH  instruction word from memory.
- imem_valid  in  1  imem_rdata is valid for the current request.
- instr  out  DATA_WIDTH  issued instruction, to sign extension and decode.
- instr_valid  out  1  instr and instr_pc are valid.
- instr_pc  out  ADDR_WIDTH  PC of the issued instruction.
- pc_plus4  out  ADDR_WIDTH  instr_pc + 4, for link-register writeback.
- misalign  out  1  one-cycle pulse: computed branch target had bits[1:0] != 0.

Behaviour:
- Reset (asynchronous, while rst=1):
  - pc=RESET_PC, state=FETCH, instr=NOP_INSTR, instr_valid=0, instr_pc=RESET_PC, misalign=0.
  - imem_req=0 while rst is high. Any outstanding request is abandoned.
  - A late imem_valid arriving after reset release for an abandoned request is not distinguished; memory must not return data for a request made before reset.
- States: FETCH, ISSUE.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_valid may arrive in the same cycle (zero-wait memory) or any later cycle.
  - On a clock edge with imem_valid=1: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, state<=ISSUE.
  - stall, pcsrc and immop are ignored in FETCH.
- ISSUE:
  - imem_req=0; imem_valid is ignored.
  - instr, instr_pc and pc_plus4 are held stable while stall=1.
  - On an edge with stall=0 (instruction consumed): pc<=next_pc, instr_valid<=0, instr<=NOP_INSTR, state<=FETCH.
- Next-PC rule:
  - next_pc = pcsrc ? (instr_pc + immop[ADDR_WIDTH-1:0]) : (instr_pc + 4).
  - Sampled only in the consuming cycle.
  - All addition is modulo 2^ADDR_WIDTH; wrap-around is silent (32'hFFFF_FFFC+4 = 0).
- Misaligned target:
  - If pcsrc=1 and target[1:0] != 0 in the consuming cycle: misalign pulses high for exactly the following cycle.
  - pc is loaded with the target with bits[1:0] forced to 00.
- Latency:
  - Minimum 2 cycles per instruction (one FETCH, one ISSUE) with zero-wait memory and no stall.
  - Each memory wait cycle adds one cycle; each stall cycle adds one cycle.
- Throughput: at most one outstanding memory request; no prefetch.
- pc_plus4 is combinational from instr_pc.

Test Plan:
1. Assert rst mid-FETCH with pc=0x40 -> same cycle imem_req=0, instr_valid=0, instr=0x00000013; after release, imem_addr=0x0 with imem_req=1.
2. Zero-wait memory returning 0x00500093 at 0x0, 0x00100113 at 0x4, stall=0, pcsrc=0 -> instr_valid high every other cycle; instr_pc 0x0 then 0x4; pc_plus4 0x4 then 0x8.
3. Memory with 3 wait cycles at address 0x8 -> imem_req held high with imem_addr=0x8 for 4 cycles; instr_valid rises on the cycle after imem_valid.
4. Issued instr_pc=0x20, stall=1 for 5 cycles, then pcsrc=1 with immop=0xFFFFFFF0 -> instr and instr_pc stable through the stall; next imem_addr=0x10; no memory request during the stall.
5. instr_pc=0x100, pcsrc=1, immop=0x6 -> misalign pulses for one cycle; next imem_addr=0x104.
6. instr_pc=0xFFFFFFFC, pcsrc=0 -> next imem_addr=0x00000000 and pc_plus4 reads 0x0 while that instruction is issued.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Instruction-fetch stage: PC register, single-outstanding imem request, issue to decode.
// Alternates FETCH (request word at pc) and ISSUE (hold instruction until consumed, then compute next pc).
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pcsrc,
    input  logic [DATA_WIDTH-1:0] immop,
    input  logic                  stall,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  imem_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    output logic                  misalign
);

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [DATA_WIDTH-1:0]   r_instr;
    logic                    r_instr_valid;
    logic [ADDR_WIDTH-1:0]   r_instr_pc;
    logic                    r_misalign;

    logic [ADDR_WIDTH-1:0]   w_seq_pc;
    logic [ADDR_WIDTH-1:0]   w_target;
    logic [ADDR_WIDTH-1:0]   w_next_pc;
    logic                    w_consume;
    logic                    w_target_misaligned;

    assign w_seq_pc            = r_instr_pc + ADDR_WIDTH'(4);
    assign w_target            = r_instr_pc + immop[ADDR_WIDTH-1:0];
    assign w_target_misaligned = pcsrc && (w_target[1:0] != 2'b00);
    // Branch targets are forced to word alignment; the misalign pulse reports the fix-up.
    assign w_next_pc           = pcsrc ? {w_target[ADDR_WIDTH-1:2], 2'b00} : w_seq_pc;
    assign w_consume           = (r_state == ISSUE) && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_instr_pc    <= RESET_PC;
            r_misalign    <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                FETCH: begin
                    if (imem_valid) begin
                        r_instr       <= imem_rdata;
                        r_instr_pc    <= r_pc;
                        r_instr_valid <= 1'b1;
                        r_state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_consume) begin
                        r_pc          <= w_next_pc;
                        r_instr       <= NOP_INSTR;
                        r_instr_valid <= 1'b0;
                        r_misalign    <= w_target_misaligned;
                        r_state       <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    // Request is gated by rst so it drops in the same cycle reset is asserted.
    assign imem_req    = (r_state == FETCH) && !rst;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign instr_pc    = r_instr_pc;
    assign pc_plus4    = w_seq_pc;
    assign misalign    = r_misalign;

endmodule
